// File: rtl/calc_control_pkg.sv
// Shared encodings and defaults for the calculator sequencing stage.
package calc_control_pkg;

  localparam int NDIG_DEF = 3;
  localparam int W_DEF    = 11;

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_OP  = 2'b01,
    S_B   = 2'b10,
    S_RES = 2'b11
  } state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

endpackage

// File: rtl/calc_alu.sv
// Sign/magnitude add/subtract of two unsigned operands.
module calc_alu
  import calc_control_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] mag,
  output logic         neg
);

  always_comb begin
    mag = a + b;
    neg = 1'b0;
    if (op == OP_SUB) begin
      if (a >= b) begin
        mag = a - b;
      end else begin
        mag = b - a;
        neg = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_control.sv
// Calculator sequencer: builds two decimal operands, holds the pending
// operator and drives a registered display value with sign.
module calc_control
  import calc_control_pkg::*;
#(
  parameter int NDIG = NDIG_DEF,
  parameter int W    = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  input  logic         is_number,
  input  logic         is_op,
  input  logic         is_c,
  input  logic         is_equ,
  input  logic [1:0]   operator,
  output logic [W-1:0] display_value,
  output logic         display_neg,
  output logic [1:0]   op_pending,
  output logic [1:0]   state_dbg
);

  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(NDIG);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, mag_q, mag_d;
  logic           neg_q, neg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   disp_d;
  logic           disp_neg_d;
  logic [W-1:0]   alu_mag;
  logic           alu_neg;
  logic [W-1:0]   digit;
  logic           num_ok, op_ok, cnt_room;

  calc_alu #(.W(W)) u_alu (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .mag (alu_mag),
    .neg (alu_neg)
  );

  // x*10 + d as shifts, truncated to W
  function automatic logic [W-1:0] append(input logic [W-1:0] x, input logic [W-1:0] d);
    return (x << 3) + (x << 1) + d;
  endfunction

  assign digit    = {{(W-4){1'b0}}, key_code};
  assign num_ok   = is_number && (key_code <= 4'd9);
  assign op_ok    = is_op && (operator != OP_NONE);
  assign cnt_room = (cnt_q < CNT_MAX);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (key_valid) begin
      if (is_c) begin
        state_d = S_A;
        a_d     = '0;
        b_d     = '0;
        mag_d   = '0;
        neg_d   = 1'b0;
        cnt_d   = '0;
        op_d    = OP_NONE;
      end else if (is_equ) begin
        if (state_q == S_B) begin
          mag_d   = alu_mag;
          neg_d   = alu_neg;
          state_d = S_RES;
        end
      end else if (is_op) begin
        if (op_ok) begin
          case (state_q)
            S_A, S_OP: begin
              op_d    = operator;
              state_d = S_OP;
            end
            S_RES: if (!neg_q) begin
              // chained result may exceed NDIG digits; lock out further appends
              a_d     = mag_q;
              op_d    = operator;
              cnt_d   = CNT_MAX;
              state_d = S_OP;
            end
            default: ;
          endcase
        end
      end else if (num_ok) begin
        case (state_q)
          S_A: if (cnt_room) begin
            a_d   = append(a_q, digit);
            cnt_d = cnt_q + CNT_ONE;
          end
          S_OP: begin
            b_d     = digit;
            cnt_d   = CNT_ONE;
            state_d = S_B;
          end
          S_B: if (cnt_room) begin
            b_d   = append(b_q, digit);
            cnt_d = cnt_q + CNT_ONE;
          end
          S_RES: begin
            a_d     = digit;
            b_d     = '0;
            cnt_d   = CNT_ONE;
            neg_d   = 1'b0;
            op_d    = OP_NONE;
            state_d = S_A;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    disp_d     = a_d;
    disp_neg_d = 1'b0;
    case (state_d)
      S_B:     disp_d = b_d;
      S_RES: begin
        disp_d     = mag_d;
        disp_neg_d = neg_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_A;
      a_q           <= '0;
      b_q           <= '0;
      mag_q         <= '0;
      neg_q         <= 1'b0;
      cnt_q         <= '0;
      op_q          <= OP_NONE;
      display_value <= '0;
      display_neg   <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      mag_q         <= mag_d;
      neg_q         <= neg_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      display_value <= disp_d;
      display_neg   <= disp_neg_d;
    end
  end

  assign op_pending = op_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_calc_control.sv
// Directed vector bench for calc_control.
module tb_calc_control;

  localparam int W = 11;
  localparam logic [3:0] FN = 4'b0001, FO = 4'b0010, FE = 4'b0100, FC = 4'b1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = '0;
  logic         is_number = 1'b0, is_op = 1'b0, is_c = 1'b0, is_equ = 1'b0;
  logic [1:0]   operator = '0;
  logic [W-1:0] display_value;
  logic         display_neg;
  logic [1:0]   op_pending;
  logic [1:0]   state_dbg;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       kv;
    logic [3:0] fl;
    logic [3:0] code;
    logic [1:0] opr;
    int         disp;
    logic       neg;
    logic [1:0] op;
    logic [1:0] st;
  } vec_t;

  vec_t vq[$];

  calc_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .is_number     (is_number),
    .is_op         (is_op),
    .is_c          (is_c),
    .is_equ        (is_equ),
    .operator      (operator),
    .display_value (display_value),
    .display_neg   (display_neg),
    .op_pending    (op_pending),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int disp, input logic neg, input logic [1:0] op, input logic [1:0] st);
    chk({nm, " display_value"}, int'(display_value), disp);
    chk({nm, " display_neg"}, int'(display_neg), int'(neg));
    chk({nm, " op_pending"}, int'(op_pending), int'(op));
    chk({nm, " state_dbg"}, int'(state_dbg), int'(st));
  endtask

  task automatic add(input logic kv, input logic [3:0] fl, input logic [3:0] code, input logic [1:0] opr,
                     input int disp, input logic neg, input logic [1:0] op, input logic [1:0] st);
    vec_t v;
    v.kv = kv; v.fl = fl; v.code = code; v.opr = opr;
    v.disp = disp; v.neg = neg; v.op = op; v.st = st;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    key_valid = v.kv;
    is_c      = v.fl[3];
    is_equ    = v.fl[2];
    is_op     = v.fl[1];
    is_number = v.fl[0];
    key_code  = v.code;
    operator  = v.opr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    key_valid = 1'b0; is_c = 1'b0; is_equ = 1'b0; is_op = 1'b0; is_number = 1'b0;
  endtask

  initial begin
    // sequence 1: 12 + 34
    add(1, FN, 1, 0,    1, 0, 0, 0);
    add(1, FN, 2, 0,   12, 0, 0, 0);
    add(1, FO, 0, 1,   12, 0, 1, 1);
    add(1, FN, 3, 0,    3, 0, 1, 2);
    add(1, FN, 4, 0,   34, 0, 1, 2);
    add(1, FE, 0, 0,   46, 0, 1, 3);
    // sequence 2: 5 - 12, operator after negative result ignored
    add(1, FN, 5, 0,    5, 0, 0, 0);
    add(1, FO, 0, 2,    5, 0, 2, 1);
    add(1, FN, 1, 0,    1, 0, 2, 2);
    add(1, FN, 2, 0,   12, 0, 2, 2);
    add(1, FE, 0, 0,    7, 1, 2, 3);
    add(1, FO, 0, 1,    7, 1, 2, 3);
    add(1, FE, 0, 0,    7, 1, 2, 3);
    // sequence 3: digit limit, no-op operator, equals in S_A
    add(1, FN, 1, 0,    1, 0, 0, 0);
    add(1, FN, 2, 0,   12, 0, 0, 0);
    add(1, FN, 3, 0,  123, 0, 0, 0);
    add(1, FN, 4, 0,  123, 0, 0, 0);
    add(1, FO, 0, 0,  123, 0, 0, 0);
    add(1, FN, 5, 0,  123, 0, 0, 0);
    add(1, FE, 0, 0,  123, 0, 0, 0);
    // clear, invalid code, priority equ over number
    add(1, FC, 0, 0,    0, 0, 0, 0);
    add(1, FN, 12, 0,   0, 0, 0, 0);
    add(1, FE|FN, 7, 0, 0, 0, 0, 0);
    // sequence 4: 999 + 999, operator replace, chain + 2
    add(1, FN, 9, 0,    9, 0, 0, 0);
    add(1, FN, 9, 0,   99, 0, 0, 0);
    add(1, FN, 9, 0,  999, 0, 0, 0);
    add(1, FO, 0, 1,  999, 0, 1, 1);
    add(1, FO, 0, 2,  999, 0, 2, 1);
    add(1, FO, 0, 1,  999, 0, 1, 1);
    add(1, FN, 9, 0,    9, 0, 1, 2);
    add(1, FN, 9, 0,   99, 0, 1, 2);
    add(1, FN, 9, 0,  999, 0, 1, 2);
    add(1, FO, 0, 2,  999, 0, 1, 2);
    add(1, FE, 0, 0, 1998, 0, 1, 3);
    add(1, FO, 0, 1, 1998, 0, 1, 1);
    add(1, FN, 2, 0,    2, 0, 1, 2);
    add(1, FE, 0, 0, 2000, 0, 1, 3);
    // clear wins over number; 4 + 7 then clear
    add(1, FC|FN, 4, 0, 0, 0, 0, 0);
    add(1, FN, 4, 0,    4, 0, 0, 0);
    add(1, FO, 0, 1,    4, 0, 1, 1);
    add(1, FN, 7, 0,    7, 0, 1, 2);
    add(1, FC, 0, 0,    0, 0, 0, 0);
    // key_valid low: flags ignored
    add(1, FN, 8, 0,    8, 0, 0, 0);
    add(0, FC, 0, 0,    8, 0, 0, 0);
    add(0, FN, 5, 0,    8, 0, 0, 0);
    // 85 - 99 -> negative, left in place for the async reset check
    add(1, FN, 5, 0,   85, 0, 0, 0);
    add(1, FO, 0, 2,   85, 0, 2, 1);
    add(1, FN, 9, 0,    9, 0, 2, 2);
    add(1, FN, 9, 0,   99, 0, 2, 2);
    add(1, FE, 0, 0,   14, 1, 2, 3);

    repeat (3) @(posedge clk);
    #1 chk_all("reset", 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i]);
      chk_all($sformatf("vec%0d", i), vq[i].disp, vq[i].neg, vq[i].op, vq[i].st);
    end
    idle();

    // asynchronous reset between clock edges clears everything at once
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    begin
      vec_t v;
      v.kv = 1; v.fl = FN; v.code = 3; v.opr = 0;
      v.disp = 3; v.neg = 0; v.op = 0; v.st = 0;
      drive(v);
      chk_all("post_rst", 3, 0, 0, 0);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
